// File: rtl/sdram_slot_arbiter.sv
// Shares SDRAM slots between video, CPU, a buffered loader and an aux byte DMA port.
// One owner is chosen per mem_sync and its address/data are held for the whole slot.
module sdram_slot_arbiter #(
    parameter int LD_FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        mem_sync,
    input  logic        phi0,
    input  logic [24:0] vid_adr,
    input  logic        cpu_req,
    input  logic [24:0] cpu_adr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_di,
    input  logic        ld_wr,
    input  logic [24:0] ld_adr,
    input  logic [7:0]  ld_data,
    output logic        ld_full,
    output logic        ld_ovf,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [24:0] aux_adr,
    input  logic [7:0]  aux_di,
    output logic        aux_ack,
    output logic [7:0]  aux_do,
    output logic [24:0] sd_adr,
    output logic        sd_we,
    output logic [7:0]  sd_di,
    input  logic [7:0]  sd_do,
    output logic [1:0]  grant
);
    // aux FSM
    // state    | meaning
    // A_IDLE   | no aux request latched
    // A_WAIT   | request latched, waiting for an idle CPU slot
    // A_ISSUED | aux access owns the current slot, data taken at next mem_sync
    // A_DONE   | ack given, waiting for aux_req to drop
    typedef enum logic [1:0] {A_IDLE, A_WAIT, A_ISSUED, A_DONE} aux_state_t;

    localparam int PTR_W = $clog2(LD_FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(LD_FIFO_DEPTH);

    logic [24:0]      ld_adr_mem  [LD_FIFO_DEPTH];
    logic [7:0]       ld_data_mem [LD_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   ld_count, ld_count_nxt;
    logic             fifo_empty, fifo_at_full, ld_push, ld_pop;

    aux_state_t  aux_state, aux_state_nxt;
    logic        aux_latch, aux_fire, aux_pending, aux_grant;
    logic        aux_we_q;
    logic [24:0] aux_adr_q;
    logic [7:0]  aux_di_q;

    logic [1:0]  slot_grant;
    logic [24:0] slot_adr;
    logic        slot_we;
    logic [7:0]  slot_di;

    assign fifo_empty   = (ld_count == '0);
    assign fifo_at_full = (ld_count == FULL_CNT);
    assign ld_pop       = mem_sync && !fifo_empty;
    // A pop in the same cycle frees the head entry, so a push at full is still accepted.
    assign ld_push      = ld_wr && (!fifo_at_full || ld_pop);

    always_comb begin
        ld_count_nxt = ld_count;
        case ({ld_push, ld_pop})
            2'b10:   ld_count_nxt = ld_count + 1'b1;
            2'b01:   ld_count_nxt = ld_count - 1'b1;
            default: ld_count_nxt = ld_count;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (ld_push) begin
            ld_adr_mem[wr_ptr]  <= ld_adr;
            ld_data_mem[wr_ptr] <= ld_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ld_count <= '0;
            ld_full  <= 1'b0;
            ld_ovf   <= 1'b0;
        end else begin
            if (ld_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (ld_pop)
                rd_ptr <= rd_ptr + 1'b1;
            ld_count <= ld_count_nxt;
            ld_full  <= (ld_count_nxt == FULL_CNT);
            if (ld_wr && !ld_push)
                ld_ovf <= 1'b1;
        end
    end

    assign aux_pending = (aux_state == A_WAIT) && aux_req;

    always_comb begin
        slot_grant = 2'd3;
        slot_adr   = cpu_adr;
        slot_we    = 1'b0;
        slot_di    = '0;
        aux_grant  = 1'b0;
        if (!fifo_empty) begin
            slot_grant = 2'd2;
            slot_adr   = ld_adr_mem[rd_ptr];
            slot_we    = 1'b1;
            slot_di    = ld_data_mem[rd_ptr];
        end else if (!phi0) begin
            slot_grant = 2'd0;
            slot_adr   = vid_adr;
        end else if (cpu_req) begin
            slot_grant = 2'd1;
            slot_adr   = cpu_adr;
            slot_we    = cpu_we;
            slot_di    = cpu_di;
        end else if (aux_pending) begin
            slot_grant = 2'd3;
            slot_adr   = aux_adr_q;
            slot_we    = aux_we_q;
            slot_di    = aux_di_q;
            aux_grant  = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sd_adr <= '0;
            sd_we  <= 1'b0;
            sd_di  <= '0;
            grant  <= 2'd0;
        end else if (mem_sync) begin
            sd_adr <= slot_adr;
            sd_we  <= slot_we;
            sd_di  <= slot_di;
            grant  <= slot_grant;
        end
    end

    always_comb begin
        aux_state_nxt = aux_state;
        aux_latch     = 1'b0;
        aux_fire      = 1'b0;
        case (aux_state)
            A_IDLE: begin
                if (aux_req) begin
                    aux_state_nxt = A_WAIT;
                    aux_latch     = 1'b1;
                end
            end
            A_WAIT: begin
                if (mem_sync && aux_grant)
                    aux_state_nxt = A_ISSUED;
                else if (!aux_req)
                    aux_state_nxt = A_IDLE;
            end
            A_ISSUED: begin
                // Completes regardless of aux_req once the slot was granted.
                if (mem_sync) begin
                    aux_state_nxt = A_DONE;
                    aux_fire      = 1'b1;
                end
            end
            A_DONE: begin
                if (!aux_req)
                    aux_state_nxt = A_IDLE;
            end
            default: aux_state_nxt = A_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            aux_state <= A_IDLE;
            aux_we_q  <= 1'b0;
            aux_adr_q <= '0;
            aux_di_q  <= '0;
            aux_ack   <= 1'b0;
            aux_do    <= '0;
        end else begin
            aux_state <= aux_state_nxt;
            aux_ack   <= aux_fire;
            if (aux_latch) begin
                aux_we_q  <= aux_we;
                aux_adr_q <= aux_adr;
                aux_di_q  <= aux_di;
            end
            if (aux_fire)
                aux_do <= sd_do;
        end
    end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Scoreboard bench for sdram_slot_arbiter: expected slot decisions are queued when a
// mem_sync is driven and compared the cycle after, when the registered outputs appear.
module tb_sdram_slot_arbiter;
    localparam int DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        mem_sync, phi0;
    logic [24:0] vid_adr, cpu_adr, ld_adr, aux_adr, sd_adr;
    logic        cpu_req, cpu_we, ld_wr, aux_req, aux_we, sd_we;
    logic [7:0]  cpu_di, ld_data, aux_di, sd_di, sd_do, aux_do;
    logic        ld_full, ld_ovf, aux_ack;
    logic [1:0]  grant;

    always #10 clk_sys = ~clk_sys;

    sdram_slot_arbiter #(.LD_FIFO_DEPTH(DEPTH)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .mem_sync(mem_sync), .phi0(phi0),
        .vid_adr(vid_adr), .cpu_req(cpu_req), .cpu_adr(cpu_adr), .cpu_we(cpu_we),
        .cpu_di(cpu_di), .ld_wr(ld_wr), .ld_adr(ld_adr), .ld_data(ld_data),
        .ld_full(ld_full), .ld_ovf(ld_ovf), .aux_req(aux_req), .aux_we(aux_we),
        .aux_adr(aux_adr), .aux_di(aux_di), .aux_ack(aux_ack), .aux_do(aux_do),
        .sd_adr(sd_adr), .sd_we(sd_we), .sd_di(sd_di), .sd_do(sd_do), .grant(grant)
    );

    typedef struct {
        logic [1:0]  grant;
        logic [24:0] adr;
        logic        we;
        logic [7:0]  di;
        logic        chk_di;
        logic        ack;
        logic [7:0]  ado;
    } slot_exp_t;

    slot_exp_t   exp_q[$];
    logic [32:0] m_fifo[$];
    slot_exp_t   mon_e;
    slot_exp_t   hold_exp;
    logic        hold_valid = 1'b0;
    logic        sync_d;
    logic        m_ovf = 1'b0, m_aux_pend = 1'b0, m_aux_issued = 1'b0, m_aux_we = 1'b0;
    logic [24:0] m_aux_adr = '0;
    logic [7:0]  m_aux_di = '0;
    logic        ld_pend = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk_sys or negedge reset_n)
        if (!reset_n) sync_d <= 1'b0;
        else          sync_d <= mem_sync;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (sync_d) begin
                check_val("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_val("grant", 64'(grant), 64'(mon_e.grant));
                    check_val("sd_adr", 64'(sd_adr), 64'(mon_e.adr));
                    check_val("sd_we", 64'(sd_we), 64'(mon_e.we));
                    if (mon_e.chk_di) check_val("sd_di", 64'(sd_di), 64'(mon_e.di));
                    check_val("aux_ack", 64'(aux_ack), 64'(mon_e.ack));
                    if (mon_e.ack) check_val("aux_do", 64'(aux_do), 64'(mon_e.ado));
                    hold_exp   = mon_e;
                    hold_valid = 1'b1;
                end
            end else begin
                check_val("aux_ack_idle", 64'(aux_ack), 64'd0);
                if (hold_valid)
                    check_val("slot_hold", 64'({grant, sd_we, sd_adr}),
                              64'({hold_exp.grant, hold_exp.we, hold_exp.adr}));
            end
        end
    end

    task automatic step();
        if (ld_pend) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back({ld_adr, ld_data});
            else                       m_ovf = 1'b1;
            ld_pend = 1'b0;
        end
        @(negedge clk_sys);
        mem_sync = 1'b0;
        ld_wr    = 1'b0;
        vid_adr  = 25'($urandom);
        cpu_adr  = 25'($urandom);
        cpu_we   = 1'($urandom);
        cpu_di   = 8'($urandom);
        check_val("ld_full", 64'(ld_full), 64'(m_fifo.size() == DEPTH));
        check_val("ld_ovf", 64'(ld_ovf), 64'(m_ovf));
    endtask

    task automatic drive_ld(input logic [24:0] adr, input logic [7:0] data);
        ld_wr   = 1'b1;
        ld_adr  = adr;
        ld_data = data;
        ld_pend = 1'b1;
    endtask

    task automatic drive_sync(input logic phi);
        slot_exp_t   e;
        logic [32:0] h;
        mem_sync = 1'b1;
        phi0     = phi;
        e.ack    = m_aux_issued;
        e.ado    = sd_do;
        m_aux_issued = 1'b0;
        e.we     = 1'b0;
        e.di     = '0;
        e.chk_di = 1'b0;
        if (m_fifo.size() != 0) begin
            h = m_fifo.pop_front();
            e.grant = 2'd2; e.adr = h[32:8]; e.we = 1'b1; e.di = h[7:0]; e.chk_di = 1'b1;
        end else if (!phi) begin
            e.grant = 2'd0; e.adr = vid_adr;
        end else if (cpu_req) begin
            e.grant = 2'd1; e.adr = cpu_adr; e.we = cpu_we; e.di = cpu_di; e.chk_di = cpu_we;
        end else if (m_aux_pend && aux_req) begin
            e.grant = 2'd3; e.adr = m_aux_adr; e.we = m_aux_we; e.di = m_aux_di;
            e.chk_di = m_aux_we;
            m_aux_pend   = 1'b0;
            m_aux_issued = 1'b1;
        end else begin
            e.grant = 2'd3; e.adr = cpu_adr;
        end
        exp_q.push_back(e);
    endtask

    task automatic slot(input logic phi);
        drive_sync(phi);
        repeat (4) step();
    endtask

    task automatic aux_start(input logic we, input logic [24:0] adr, input logic [7:0] di);
        aux_req = 1'b1; aux_we = we; aux_adr = adr; aux_di = di;
        m_aux_pend = 1'b1; m_aux_we = we; m_aux_adr = adr; m_aux_di = di;
        step();
        // The request fields must have been latched by now.
        aux_we = 1'b0; aux_adr = '0; aux_di = '0;
    endtask

    task automatic aux_drop();
        aux_req    = 1'b0;
        m_aux_pend = 1'b0;
        step();
    endtask

    task automatic check_reset_outputs();
        check_val("rst_sd_adr", 64'(sd_adr), 64'd0);
        check_val("rst_sd_we", 64'(sd_we), 64'd0);
        check_val("rst_sd_di", 64'(sd_di), 64'd0);
        check_val("rst_grant", 64'(grant), 64'd0);
        check_val("rst_ld_full", 64'(ld_full), 64'd0);
        check_val("rst_ld_ovf", 64'(ld_ovf), 64'd0);
        check_val("rst_aux_ack", 64'(aux_ack), 64'd0);
        check_val("rst_aux_do", 64'(aux_do), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; mem_sync = 1'b0; phi0 = 1'b0; vid_adr = '0; cpu_req = 1'b0;
        cpu_adr = '0; cpu_we = 1'b0; cpu_di = '0; ld_wr = 1'b0; ld_adr = '0; ld_data = '0;
        aux_req = 1'b0; aux_we = 1'b0; aux_adr = '0; aux_di = '0; sd_do = '0;
        repeat (3) @(negedge clk_sys);
        #1 check_reset_outputs();
        @(negedge clk_sys);
        reset_n = 1'b1;
        step();

        // video/CPU alternation
        cpu_req = 1'b1;
        slot(1'b0); slot(1'b1); slot(1'b0); slot(1'b1);

        // aux read in the first idle CPU slot, data returned one slot later
        cpu_req = 1'b0;
        aux_start(1'b0, 25'h13000, 8'h00);
        slot(1'b1);
        sd_do = 8'h5C;
        slot(1'b0);
        aux_drop();

        // aux starved while CPU owns every CPU slot
        cpu_req = 1'b1;
        aux_start(1'b1, 25'h01234, 8'h77);
        repeat (10) begin
            slot(1'b0);
            slot(1'b1);
        end
        cpu_req = 1'b0;
        slot(1'b0);
        slot(1'b1);
        sd_do = 8'h3E;
        slot(1'b0);
        aux_drop();

        // request withdrawn before any grant: idle slot, no ack
        aux_start(1'b0, 25'h0ABCD, 8'h00);
        slot(1'b0);
        aux_drop();
        slot(1'b1);

        // loader burst overflowing a 4-deep FIFO, then drained in order
        for (int i = 0; i < 6; i++) begin
            drive_ld(25'h80000 + 25'(i), 8'hA0 + 8'(i));
            step();
        end
        for (int i = 0; i < 6; i++) slot(1'(i));

        // reset with 3 bytes queued and aux in flight
        aux_start(1'b0, 25'h13000, 8'h00);
        slot(1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_ld(25'h70000 + 25'(i), 8'hC0 + 8'(i));
            step();
        end
        reset_n = 1'b0;
        aux_req = 1'b0;
        hold_valid = 1'b0;
        m_fifo.delete();
        m_ovf = 1'b0; m_aux_pend = 1'b0; m_aux_issued = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        step();
        slot(1'b0); slot(1'b1); slot(1'b0);

        // full FIFO with a push coincident with a pop
        for (int i = 0; i < 4; i++) begin
            drive_ld(25'h90000 + 25'(i), 8'hB0 + 8'(i));
            step();
        end
        drive_sync(1'b0);
        drive_ld(25'h90004, 8'hB4);
        repeat (4) step();
        for (int i = 0; i < 5; i++) slot(1'(i + 1));

        check_val("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
